alu_arb_ctrl: RTL and testbench
===============================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width of the shared ALU.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 2 bits, one request-valid bit per requester (bit i = requester i).
REQ-005 The block SHALL have port req_ready, output, 2 bits, one request-accept bit per requester.
REQ-006 The block SHALL have port req_op, input, 8 bits, 4-bit ALU select per requester; bits [4i+3:4i] belong to requester i.
REQ-007 The block SHALL have port req_a, input, 2*WIDTH bits, operand A per requester; bits [WIDTH*i+WIDTH-1:WIDTH*i] belong to requester i.
REQ-008 The block SHALL have port req_b, input, 2*WIDTH bits, operand B per requester, packed like req_a.
REQ-009 The block SHALL have port rsp_valid, output, 2 bits, one response-valid bit per requester.
REQ-010 The block SHALL have port rsp_ready, input, 2 bits, one response-accept bit per requester.
REQ-011 The block SHALL have port rsp_data, output, WIDTH+1 bits, the result; bit WIDTH carries the ALU carry-out.
REQ-012 The block SHALL have port alu_a, output, WIDTH bits, operand A driven to the external ALU.
REQ-013 The block SHALL have port alu_b, output, WIDTH bits, operand B driven to the external ALU.
REQ-014 The block SHALL have port alu_sel, output, 4 bits, the select driven to the external ALU.
REQ-015 The block SHALL have port alu_out, input, WIDTH+1 bits, the combinational result from the ALU.
REQ-016 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-017 The block SHALL have port op_cnt, output, 8 bits, the count of completed responses.

Function
REQ-018 The block SHALL use an FSM with three states: IDLE, EXEC and RESP.
REQ-019 In IDLE, req_ready SHALL be one-hot on the granted requester, or 0 when neither req_valid bit is set; in every other state req_ready SHALL be 0.
REQ-020 Arbitration SHALL be round-robin: a lone request is granted; for simultaneous requests, the requester named by priority pointer ptr wins.
REQ-021 On a handshake (req_valid[i] & req_ready[i]), the block SHALL latch op, a, b and the requester id, set ptr to the other requester, and move IDLE->EXEC.
REQ-022 In EXEC, the block SHALL drive the latched values on alu_sel, alu_a and alu_b, register alu_out into rsp_data at the clock edge ending EXEC, and move EXEC->RESP; EXEC SHALL last exactly 1 cycle.
REQ-023 alu_a, alu_b and alu_sel SHALL hold their last issued values outside EXEC.
REQ-024 In RESP, rsp_valid SHALL be high on the latched id only, and rsp_data SHALL stay stable until the response is accepted.
REQ-025 On rsp_ready[id], the block SHALL move RESP->IDLE and increment op_cnt by 1 modulo 256 (255 wraps to 0).
REQ-026 Latency SHALL be: handshake in cycle N, EXEC in cycle N+1, rsp_valid asserted in cycle N+2; sustained throughput SHALL be one operation per 3 cycles when rsp_ready is held high.
REQ-027 The block SHALL have at most one transaction outstanding; requests arriving in EXEC or RESP SHALL wait without being dropped.
REQ-028 All 16 alu_sel codes SHALL be passed through unmodified; the block SHALL NOT interpret op.
REQ-029 A req_valid bit that deasserts before its handshake SHALL NOT be granted and SHALL NOT move ptr.

Reset
REQ-030 When rst_n=0 at a clock edge, the block SHALL set: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, alu_a=0, alu_b=0, alu_sel=0, op_cnt=0, busy=0.
REQ-031 A reset asserted in EXEC or RESP SHALL abort the in-flight transaction with no response issued and no increment of op_cnt.
REQ-032 req_ready SHALL be 0 in the first cycle after rst_n is released, because the registered grant becomes valid from the next cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) and the ALU select constants: logic 00xx, arithmetic 01xx, shift 1xxx.
REQ-034 The block SHALL contain exactly one sub-module, rr_arb2, a two-requester round-robin grant generator taking req_valid and ptr and producing a one-hot grant.
REQ-035 The ALU SHALL remain external; alu_arb_ctrl SHALL contain no arithmetic except the op_cnt increment.

Verification
REQ-036 Scenario 1: requester 0 sends op=0100, a=0100, b=1110 -> alu_sel=0100 in cycle N+1; rsp_valid=01 and rsp_data=10010 in cycle N+2.
REQ-037 Scenario 2: both requesters valid in the same cycle after reset -> requester 0 served first, then requester 1, then requester 0 again while both stay valid.
REQ-038 Scenario 3: hold rsp_ready=0 for 5 cycles in RESP -> rsp_data stays stable, req_ready=00, busy=1, and op_cnt does not change.
REQ-039 Scenario 4: drive rst_n=0 during EXEC -> next cycle state=IDLE, rsp_valid=00, op_cnt unchanged at 0.
REQ-040 Scenario 5: complete 256 back-to-back operations -> op_cnt wraps from 255 to 0, with no gaps beyond the 3-cycle cadence.
REQ-041 Scenario 6: run all 16 ops with a=0100, b=1110 against the ALU model -> each rsp_data matches the model (e.g. op 0000 -> 00100, op 1000 -> 00010).

Source files
------------

// File: rtl/alu_arb_ctrl_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding and the
// ALU select map (logic 00xx, arithmetic 01xx, shift 1xxx).
package alu_arb_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Select codes are only carried through by the controller; the external
  // ALU gives them meaning.
  localparam logic [3:0] SEL_AND   = 4'b0000;
  localparam logic [3:0] SEL_OR    = 4'b0001;
  localparam logic [3:0] SEL_XOR   = 4'b0010;
  localparam logic [3:0] SEL_NOT   = 4'b0011;
  localparam logic [3:0] SEL_ADD   = 4'b0100;
  localparam logic [3:0] SEL_SUB   = 4'b0101;
  localparam logic [3:0] SEL_INC   = 4'b0110;
  localparam logic [3:0] SEL_DEC   = 4'b0111;
  localparam logic [3:0] SEL_SHR   = 4'b1000;
  localparam logic [3:0] SEL_SHL   = 4'b1001;
  localparam logic [3:0] SEL_ROR   = 4'b1010;
  localparam logic [3:0] SEL_ROL   = 4'b1011;
  localparam logic [3:0] SEL_ASR   = 4'b1100;
  localparam logic [3:0] SEL_SHRB  = 4'b1101;
  localparam logic [3:0] SEL_SHLB  = 4'b1110;
  localparam logic [3:0] SEL_PASSB = 4'b1111;

endpackage

// File: rtl/alu_arb_ctrl_rr_arb2.sv
// Two-requester round-robin grant: a lone request wins outright, a tie goes
// to the requester named by ptr_i.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] |  ptr_i);

endmodule

// File: rtl/alu_arb_ctrl.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one transaction at a time: IDLE (grant) -> EXEC (1 cycle) -> RESP (hold).
module alu_arb_ctrl
  import alu_arb_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH:0]     rsp_data,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  input  logic [WIDTH:0]     alu_out,
  output logic               busy,
  output logic [7:0]         op_cnt
);

  state_t             state_q, state_d;
  logic               ptr_q;
  logic               armed_q;
  logic               id_q;
  logic [3:0]         sel_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     data_q;
  logic [7:0]         cnt_q;

  logic [1:0]         gnt;
  logic               hs;
  logic               hs_id;
  logic               rsp_fire;

  rr_arb2 u_rr_arb2 (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // armed_q holds grants off for the first cycle after reset is released.
  assign req_ready = (state_q == ST_IDLE && armed_q) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign hs_id     = req_ready[1];
  assign rsp_fire  = (state_q == ST_RESP) && rsp_ready[id_q];

  assign rsp_valid = (state_q != ST_RESP) ? 2'b00 : (id_q ? 2'b10 : 2'b01);
  assign rsp_data  = data_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_cnt    = cnt_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      armed_q <= 1'b0;
      id_q    <= 1'b0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (hs) begin
        id_q  <= hs_id;
        ptr_q <= ~hs_id;
        sel_q <= hs_id ? req_op[7:4] : req_op[3:0];
        a_q   <= hs_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        b_q   <= hs_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      end
      if (state_q == ST_EXEC) data_q <= alu_out;
      if (rsp_fire) cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Randomised and directed bench for alu_arb_ctrl against a transaction-level
// reference model; the external ALU is modelled here as well.
module tb_alu_arb_ctrl;
  import alu_arb_ctrl_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]     req_op;
  logic [2*W-1:0] req_a, req_b;
  logic [W:0]     rsp_data, alu_out;
  logic [W-1:0]   alu_a, alu_b;
  logic [3:0]     alu_sel;
  logic           busy;
  logic [7:0]     op_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arb_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  function automatic logic [4:0] alu_ref(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      SEL_AND:  return {1'b0, a & b};
      SEL_OR:   return {1'b0, a | b};
      SEL_XOR:  return {1'b0, a ^ b};
      SEL_NOT:  return {1'b0, ~a};
      SEL_ADD:  return {1'b0, a} + {1'b0, b};
      SEL_SUB:  return {1'b0, a} - {1'b0, b};
      SEL_INC:  return {1'b0, a} + 5'd1;
      SEL_DEC:  return {1'b0, a} - 5'd1;
      SEL_SHR:  return {a[0], 4'(a >> 1)};
      SEL_SHL:  return {a[3], 4'(a << 1)};
      SEL_ROR:  return {1'b0, 4'((a >> 1) | (a << 3))};
      SEL_ROL:  return {1'b0, 4'((a << 1) | (a >> 3))};
      SEL_ASR:  return {a[0], a[3], a[3:1]};
      SEL_SHRB: return {1'b0, 4'(a >> b[1:0])};
      SEL_SHLB: return {1'b0, 4'(a << b[1:0])};
      default:  return {1'b0, b};
    endcase
  endfunction

  assign alu_out = alu_ref(alu_sel, alu_a, alu_b);

  // Reference model: at most one transaction in flight, aged in cycles since
  // its grant (1 = being executed, 2 = waiting for response acceptance).
  bit         m_init  = 0;
  bit         m_armed = 0;
  bit         m_txn   = 0;
  int         m_age   = 0;
  int         m_id    = 0;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  logic [3:0] m_sel   = '0;
  logic [3:0] m_a     = '0;
  logic [3:0] m_b     = '0;
  logic [4:0] m_res   = '0;
  bit         last_hs = 0;
  int         last_id = 0;

  function automatic logic [1:0] exp_ready(input logic [1:0] v);
    int w;
    if (m_txn || !m_armed || v == 2'b00) return 2'b00;
    w = (v == 2'b11) ? m_ptr : (v[1] ? 1 : 0);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic [1:0] v, input logic [7:0] op,
                       input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic [1:0] rr);
    @(negedge clk);
    rst_n     = rst;
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    if (m_init) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready(v)));
      check("rsp_valid", 32'(rsp_valid),
            32'((m_txn && m_age == 2) ? ((m_id == 1) ? 2'b10 : 2'b01) : 2'b00));
      check("rsp_data", 32'(rsp_data), 32'(m_res));
      check("busy", 32'(busy), 32'(m_txn));
      check("op_cnt", 32'(op_cnt), 32'(m_cnt));
      check("alu_sel", 32'(alu_sel), 32'(m_sel));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
    end
  endtask

  task automatic tick();
    logic [1:0] rdy;
    int w;
    @(posedge clk);
    last_hs = 0;
    if (!rst_n) begin
      m_init = 1; m_armed = 0; m_txn = 0; m_age = 0; m_ptr = 0; m_cnt = 0;
      m_sel = '0; m_a = '0; m_b = '0; m_res = '0;
    end else begin
      rdy = exp_ready(req_valid);
      if (!m_txn) begin
        if (rdy != 2'b00) begin
          w       = rdy[1] ? 1 : 0;
          m_id    = w;
          m_ptr   = 1 - w;
          m_sel   = req_op[4*w +: 4];
          m_a     = req_a[W*w +: W];
          m_b     = req_b[W*w +: W];
          m_txn   = 1;
          m_age   = 1;
          last_hs = 1;
          last_id = w;
        end
      end else if (m_age == 1) begin
        m_res = alu_ref(m_sel, m_a, m_b);
        m_age = 2;
      end else if (rsp_ready[m_id]) begin
        m_txn = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
      m_armed = 1;
    end
  endtask

  task automatic cyc(input logic rst, input logic [1:0] v, input logic [1:0] rr);
    drive(rst, v, 8'(($urandom)), 8'(($urandom)), 8'(($urandom)), rr);
    tick();
  endtask

  task automatic do_reset();
    cyc(1'b0, 2'b00, 2'b00);
    cyc(1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int served [3];
    int n_served;
    int n_hs;
    bit saw255;

    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;

    // Scenario 2: both requesters valid straight out of reset.
    do_reset();
    drive(1'b1, 2'b11, 8'h54, 8'h00, 8'h00, 2'b11);
    check("s2_ready_after_rst", 32'(req_ready), 32'h0);
    tick();
    n_served = 0;
    for (int i = 0; i < 12 && n_served < 3; i++) begin
      cyc(1'b1, 2'b11, 2'b11);
      if (last_hs) begin
        served[n_served] = last_id;
        n_served++;
      end
    end
    check("s2_served_count", 32'(n_served), 32'd3);
    if (n_served == 3) begin
      check("s2_first", 32'(served[0]), 32'd0);
      check("s2_second", 32'(served[1]), 32'd1);
      check("s2_third", 32'(served[2]), 32'd0);
    end

    // Scenario 1: single ADD from requester 0.
    do_reset();
    cyc(1'b1, 2'b00, 2'b11);
    drive(1'b1, 2'b01, 8'h04, 8'h04, 8'h0E, 2'b11);
    check("s1_ready", 32'(req_ready), 32'h1);
    tick();
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 2'b11);
    check("s1_alu_sel", 32'(alu_sel), 32'h4);
    check("s1_alu_a", 32'(alu_a), 32'h4);
    check("s1_alu_b", 32'(alu_b), 32'hE);
    tick();
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 2'b11);
    check("s1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("s1_rsp_data", 32'(rsp_data), 32'h12);
    tick();
    cyc(1'b1, 2'b00, 2'b11);

    // Scenario 3: response back-pressured for 5 cycles while both requesters wait.
    drive(1'b1, 2'b10, 8'h50, 8'h30, 8'h70, 2'b00);
    tick();
    cyc(1'b1, 2'b11, 2'b00);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 2'b00);
      check("s3_rsp_data", 32'(rsp_data), 32'h1C);
      check("s3_ready", 32'(req_ready), 32'h0);
      check("s3_busy", 32'(busy), 32'h1);
      check("s3_op_cnt", 32'(op_cnt), 32'd1);
      tick();
    end
    cyc(1'b1, 2'b00, 2'b10);
    cyc(1'b1, 2'b00, 2'b11);

    // Scenario 4: reset during EXEC aborts the transaction.
    do_reset();
    cyc(1'b1, 2'b00, 2'b11);
    cyc(1'b1, 2'b01, 2'b11);
    cyc(1'b0, 2'b00, 2'b11);
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 2'b11);
    check("s4_busy", 32'(busy), 32'h0);
    check("s4_rsp_valid", 32'(rsp_valid), 32'h0);
    check("s4_op_cnt", 32'(op_cnt), 32'h0);
    tick();
    cyc(1'b1, 2'b00, 2'b11);

    // Scenario 5: 256 back-to-back operations wrap op_cnt.
    do_reset();
    n_hs = 0;
    saw255 = 0;
    for (int i = 0; i < 769; i++) begin
      drive(1'b1, 2'b11, 8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 2'b11);
      if ((req_valid & req_ready) != 2'b00) n_hs++;
      if (op_cnt == 8'd255) saw255 = 1;
      tick();
    end
    check("s5_handshakes", 32'(n_hs), 32'd256);
    check("s5_saw_255", 32'(saw255), 32'd1);
    drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 2'b11);
    check("s5_wrap", 32'(op_cnt), 32'd0);
    tick();

    // Scenario 6: every select code with a=0100, b=1110.
    do_reset();
    cyc(1'b1, 2'b00, 2'b11);
    for (int op = 0; op < 16; op++) begin
      drive(1'b1, 2'b01, {4'h0, 4'(op)}, 8'h04, 8'h0E, 2'b11);
      tick();
      cyc(1'b1, 2'b00, 2'b11);
      drive(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 2'b11);
      check("s6_rsp_data", 32'(rsp_data), 32'(alu_ref(4'(op), 4'h4, 4'hE)));
      if (op == 0) check("s6_and", 32'(rsp_data), 32'h04);
      if (op == 8) check("s6_shr", 32'(rsp_data), 32'h02);
      tick();
    end

    // Random traffic: flickering valids, back-pressure and occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) != 0), 2'(($urandom)), 2'(($urandom)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
